hls_mem_responder: RTL and testbench

- Target side of an HLS-generated kernel's single-port array interface (address0/ce0/we0/d0/q0) plus initiator side of its ap_ctrl_hs handshake.
- Stands in for the BRAM and the host so a kernel such as the unsharp-mask core can be preloaded, started, run and read back in simulation or on FPGA.
- One instance serves one array argument. The top level instantiates one per array; exactly one instance has start control enabled.

---
 rtl/hls_resp_pkg.sv | 15 +
 rtl/hls_sp_ram.sv | 25 ++
 rtl/hls_mem_responder.sv | 157 +++++++++++++++
 tb/tb_hls_mem_responder.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_resp_pkg.sv
// rtl/hls_resp_pkg.sv - shared types and default widths for the HLS memory responder
package hls_resp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DEPTH  = 1024;
  localparam int CNT_W      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/hls_sp_ram.sv
// rtl/hls_sp_ram.sv - single-port synchronous RAM, registered read, array not reset
module hls_sp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // q only moves on a read, so a write leaves the last read data in place
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    q         <= mem[addr];
    end
  end

endmodule

// File: rtl/hls_mem_responder.sv
// rtl/hls_mem_responder.sv - BRAM stand-in for one HLS array argument plus ap_ctrl_hs initiator
module hls_mem_responder
  import hls_resp_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CTRL_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] k_address0,
  input  logic              k_ce0,
  input  logic              k_we0,
  input  logic [DATA_W-1:0] k_d0,
  output logic [DATA_W-1:0] k_q0,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_idle,
  input  logic              h_valid,
  output logic              h_ready,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              h_start,
  output logic              busy,
  output logic              done,
  output logic              oor_err,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  state_t            state, state_nxt;
  logic              done_nxt, cnt_clr, cnt_en;
  logic              h_acc, in_range, ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_q, rd_data;
  logic              k_rd_q, h_rd_q, rd_oor_q;
  logic [DATA_W-1:0] k_q_hold, h_rdata_hold;
  logic              ctrl_unused;

  assign ctrl_unused = ap_idle;

  // Kernel owns the RAM whenever ce0 is high; the host only gets idle cycles
  assign h_ready   = !k_ce0;
  assign h_acc     = h_valid && !k_ce0;
  assign ram_addr  = k_ce0 ? k_address0 : h_addr;
  assign ram_we    = k_ce0 ? k_we0 : h_we;
  assign ram_wdata = k_ce0 ? k_d0 : h_wdata;
  assign in_range  = {1'b0, ram_addr} < DEPTH_L;
  assign ram_en    = (k_ce0 || h_acc) && in_range;

  hls_sp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // RAM q is shared; each port shows it only in the cycle after its own read
  assign rd_data  = rd_oor_q ? '0 : ram_q;
  assign k_q0     = k_rd_q ? rd_data : k_q_hold;
  assign h_rvalid = h_rd_q;
  assign h_rdata  = h_rd_q ? rd_data : h_rdata_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_rd_q       <= 1'b0;
      h_rd_q       <= 1'b0;
      rd_oor_q     <= 1'b0;
      k_q_hold     <= '0;
      h_rdata_hold <= '0;
      oor_err      <= 1'b0;
    end else begin
      k_rd_q   <= k_ce0 && !k_we0;
      h_rd_q   <= h_acc && !h_we;
      rd_oor_q <= !in_range;
      if (k_rd_q) k_q_hold     <= rd_data;
      if (h_rd_q) h_rdata_hold <= rd_data;
      if ((k_ce0 || h_acc) && !in_range) oor_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ap_start  = 1'b0;
    busy      = 1'b0;
    done_nxt  = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (CTRL_EN != 0 && h_start) begin
          state_nxt = START;
          cnt_clr   = 1'b1;
        end
      end
      START: begin
        ap_start = 1'b1;
        busy     = 1'b1;
        if (ap_ready) begin
          if (ap_done) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (ap_done) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Without start control there is no run window, so every kernel access counts
  assign cnt_en = (CTRL_EN == 0) || busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (cnt_clr) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (cnt_en && k_ce0) begin
      if (!k_we0 && rd_cnt != {CNT_W{1'b1}}) rd_cnt <= rd_cnt + 1'b1;
      if (k_we0 && wr_cnt != {CNT_W{1'b1}})  wr_cnt <= wr_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hls_mem_responder.sv
// tb/tb_hls_mem_responder.sv - scoreboard bench for hls_mem_responder (default and DEPTH=1000 instances)
module tb_hls_mem_responder;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] k_address0 = '0;
  logic          k_ce0 = 1'b0, k_we0 = 1'b0;
  logic [DW-1:0] k_d0 = '0;
  logic          ap_ready = 1'b0, ap_done = 1'b0, ap_idle = 1'b0;
  logic          h_valid = 1'b0, h_we = 1'b0, h_start = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_wdata = '0;

  logic [DW-1:0] k_q0, h_rdata, o_k_q0, o_h_rdata;
  logic          ap_start, h_ready, h_rvalid, busy, done, oor_err;
  logic          o_ap_start, o_h_ready, o_h_rvalid, o_busy, o_done, o_oor_err;
  logic [31:0]   rd_cnt, wr_cnt, o_rd_cnt, o_wr_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int done_seen = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_o_q[$];

  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_seen++;

  hls_mem_responder u_dut (
    .clk(clk), .rst(rst), .k_address0(k_address0), .k_ce0(k_ce0), .k_we0(k_we0),
    .k_d0(k_d0), .k_q0(k_q0), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_idle(ap_idle), .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_start(h_start),
    .busy(busy), .done(done), .oor_err(oor_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  hls_mem_responder #(.DEPTH(1000), .CTRL_EN(0)) u_oor (
    .clk(clk), .rst(rst), .k_address0(k_address0), .k_ce0(k_ce0), .k_we0(k_we0),
    .k_d0(k_d0), .k_q0(o_k_q0), .ap_start(o_ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_idle(ap_idle), .h_valid(h_valid), .h_ready(o_h_ready), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_rvalid(o_h_rvalid), .h_rdata(o_h_rdata), .h_start(h_start),
    .busy(o_busy), .done(o_done), .oor_err(o_oor_err), .rd_cnt(o_rd_cnt), .wr_cnt(o_wr_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the current host request until an edge accepts it; returns after that edge
  task automatic wait_accept();
    int n = 0;
    while (!h_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: h_ready stuck %b after %0d cycles, required 1", h_ready, n);
    end
    step();
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    h_valid = 1'b1; h_we = 1'b1; h_addr = a; h_wdata = d;
    wait_accept();
    h_valid = 1'b0; h_we = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic v, output logic [DW-1:0] d,
                           output logic ov, output logic [DW-1:0] od, output logic v_after);
    h_valid = 1'b1; h_we = 1'b0; h_addr = a;
    wait_accept();
    h_valid = 1'b0;
    v = h_rvalid; d = h_rdata; ov = o_h_rvalid; od = o_h_rdata;
    step();
    v_after = h_rvalid | o_h_rvalid;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({k_q0, h_rvalid, h_rdata, ap_start, busy, done, oor_err, rd_cnt, wr_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: actual q=%h rv=%b rd=%h st=%b busy=%b done=%b oor=%b rc=%0d wc=%0d, required all 0",
               k_q0, h_rvalid, h_rdata, ap_start, busy, done, oor_err, rd_cnt, wr_cnt);
    end
    n_checks++;
    if ({o_k_q0, o_h_rvalid, o_h_rdata, o_ap_start, o_busy, o_done, o_oor_err, o_rd_cnt, o_wr_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_oor_inst: actual nonzero output, required all 0");
    end
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (h_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: actual h_ready=%b busy=%b, required 1/0", h_ready, busy);
    end
  endtask

  task automatic test_out_of_range();
    logic v, ov, va;
    logic [DW-1:0] d, od, e, eo;
    host_write(10'd10, 32'h0000_0A0A);
    n_checks++;
    if (o_oor_err !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_before: actual %b, required 0", o_oor_err);
    end
    k_ce0 = 1'b1; k_we0 = 1'b1; k_address0 = 10'd1010; k_d0 = 32'hDEAD_BEEF;
    step();
    k_ce0 = 1'b0; k_we0 = 1'b0;
    n_checks++;
    if (o_oor_err !== 1'b1 || oor_err !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_set: actual oor=%b dut_oor=%b, required 1/0", o_oor_err, oor_err);
    end
    n_checks++;
    if (o_wr_cnt !== 32'd1 || wr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL wr_cnt_idle: actual ctrl0=%0d ctrl1=%0d, required 1/0", o_wr_cnt, wr_cnt);
    end
    exp_q.push_back(32'hDEAD_BEEF); exp_o_q.push_back(32'h0);
    host_read(10'd1010, v, d, ov, od, va);
    e = exp_q.pop_front(); eo = exp_o_q.pop_front();
    n_checks++;
    if (v !== 1'b1 || ov !== 1'b1 || va !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_rvalid: actual %b/%b after=%b, required 1/1 after=0", v, ov, va);
    end
    n_checks++;
    if (od !== eo || d !== e) begin
      n_fail++;
      $display("FAIL oor_rdata: actual %h/%h, required %h/%h", od, d, eo, e);
    end
    exp_o_q.push_back(32'h0000_0A0A);
    host_read(10'd10, v, d, ov, od, va);
    eo = exp_o_q.pop_front();
    n_checks++;
    if (od !== eo) begin
      n_fail++;
      $display("FAIL oor_alias: actual %h, required %h", od, eo);
    end
    k_ce0 = 1'b1; k_address0 = 10'd1010;
    step();
    k_ce0 = 1'b0;
    n_checks++;
    if (o_k_q0 !== 32'h0 || k_q0 !== 32'hDEAD_BEEF || o_rd_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL oor_kread: actual q=%h dut_q=%h rc=%0d, required 0/deadbeef/1", o_k_q0, k_q0, o_rd_cnt);
    end
    step(); step();
    n_checks++;
    if (o_oor_err !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_sticky: actual %b, required 1", o_oor_err);
    end
  endtask

  task automatic test_host_preload();
    logic v, ov, va;
    logic [DW-1:0] d, od, e, eo;
    logic [AW-1:0] addrs [2];
    logic [DW-1:0] vals [2];
    addrs[0] = 10'd5;    vals[0] = 32'hA5A5_0001;
    addrs[1] = 10'd1023; vals[1] = 32'h0000_00FF;
    for (int i = 0; i < 2; i++) host_write(addrs[i], vals[i]);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(vals[i]);
      exp_o_q.push_back(i == 0 ? vals[0] : 32'h0);
      host_read(addrs[i], v, d, ov, od, va);
      e = exp_q.pop_front(); eo = exp_o_q.pop_front();
      n_checks++;
      if (v !== 1'b1 || va !== 1'b0 || d !== e) begin
        n_fail++;
        $display("FAIL preload_read[%0d]: actual rv=%b after=%b data=%h, required 1/0/%h", i, v, va, d, e);
      end
      n_checks++;
      if (od !== eo) begin
        n_fail++;
        $display("FAIL preload_read_oor_inst[%0d]: actual %h, required %h", i, od, eo);
      end
    end
    n_checks++;
    if (oor_err !== 1'b0) begin
      n_fail++;
      $display("FAIL preload_oor: actual %b, required 0", oor_err);
    end
  endtask

  task automatic test_kernel_read();
    logic v, ov, va;
    logic [DW-1:0] d, od, e;
    host_write(10'd7, 32'h0000_1234);
    exp_q.push_back(32'h0000_1234);
    k_ce0 = 1'b1; k_we0 = 1'b0; k_address0 = 10'd7;
    step();
    k_ce0 = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (k_q0 !== e) begin
      n_fail++;
      $display("FAIL kread_latency: actual %h, required %h", k_q0, e);
    end
    step(); step();
    n_checks++;
    if (k_q0 !== e) begin
      n_fail++;
      $display("FAIL kread_hold: actual %h, required %h", k_q0, e);
    end
    host_read(10'd5, v, d, ov, od, va);
    k_ce0 = 1'b1; k_we0 = 1'b1; k_address0 = 10'd8; k_d0 = 32'h5555_5555;
    step();
    k_ce0 = 1'b0; k_we0 = 1'b0;
    n_checks++;
    if (k_q0 !== e) begin
      n_fail++;
      $display("FAIL kread_hold_after_host_and_write: actual %h, required %h", k_q0, e);
    end
  endtask

  task automatic test_arbitration();
    logic v, ov, va;
    logic [DW-1:0] d, od, e;
    h_valid = 1'b1; h_we = 1'b0; h_addr = 10'd5;
    exp_q.push_back(32'hA5A5_0001);
    for (int i = 0; i < 3; i++) begin
      k_ce0 = 1'b1; k_we0 = 1'b1; k_address0 = AW'(20 + i); k_d0 = 32'hC0DE_0000 + i;
      #1;
      n_checks++;
      if (h_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL arb_stall[%0d]: actual h_ready=%b, required 0", i, h_ready);
      end
      step();
    end
    k_ce0 = 1'b0; k_we0 = 1'b0;
    #1;
    n_checks++;
    if (h_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arb_release: actual h_ready=%b, required 1", h_ready);
    end
    step();
    h_valid = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (h_rvalid !== 1'b1 || h_rdata !== e) begin
      n_fail++;
      $display("FAIL arb_read: actual rv=%b data=%h, required 1/%h", h_rvalid, h_rdata, e);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'hC0DE_0000 + i);
      host_read(AW'(20 + i), v, d, ov, od, va);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL arb_kwrite[%0d]: actual %h, required %h", i, d, e);
      end
    end
  endtask

  task automatic test_ap_ctrl_run();
    int seen0;
    seen0 = done_seen;
    h_start = 1'b1;
    step();
    h_start = 1'b0;
    for (int c = 1; c < 4; c++) begin
      n_checks++;
      if (ap_start !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL start_hold[%0d]: actual ap_start=%b busy=%b, required 1/1", c, ap_start, busy);
      end
      step();
    end
    ap_ready = 1'b1;
    step();
    ap_ready = 1'b0;
    n_checks++;
    if (ap_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_drop: actual ap_start=%b busy=%b, required 0/1", ap_start, busy);
    end
    for (int i = 0; i < 13; i++) begin
      k_ce0 = 1'b1; k_we0 = (i % 4 == 3); k_address0 = AW'(100 + i); k_d0 = DW'(i);
      h_start = (i == 5);
      step();
      h_start = 1'b0;
      if (i == 5) begin
        n_checks++;
        if (ap_start !== 1'b0 || busy !== 1'b1 || o_busy !== 1'b0 || o_ap_start !== 1'b0) begin
          n_fail++;
          $display("FAIL restart_ignored: actual ap_start=%b busy=%b o_busy=%b o_st=%b, required 0/1/0/0",
                   ap_start, busy, o_busy, o_ap_start);
        end
      end
    end
    k_ce0 = 1'b0; k_we0 = 1'b0;
    step(); step(); step();
    n_checks++;
    if (busy !== 1'b1 || done_seen != seen0) begin
      n_fail++;
      $display("FAIL run_before_done: actual busy=%b dones=%0d, required 1/%0d", busy, done_seen, seen0);
    end
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: actual done=%b busy=%b, required 1/0", done, busy);
    end
    n_checks++;
    if (rd_cnt !== 32'd10 || wr_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL run_counts: actual rd=%0d wr=%0d, required 10/3", rd_cnt, wr_cnt);
    end
    k_ce0 = 1'b1; k_address0 = 10'd5;
    step();
    k_ce0 = 1'b0;
    step(); step();
    n_checks++;
    if (done !== 1'b0 || done_seen != seen0 + 1 || rd_cnt !== 32'd10) begin
      n_fail++;
      $display("FAIL after_done: actual done=%b dones=%0d rd=%0d, required 0/%0d/10", done, done_seen - seen0, rd_cnt, 1);
    end
  endtask

  task automatic test_ready_done_same_cycle();
    h_start = 1'b1;
    step();
    h_start = 1'b0;
    ap_ready = 1'b1; ap_done = 1'b1;
    step();
    ap_ready = 1'b0; ap_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1 || ap_start !== 1'b0 || rd_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL ready_done_same: actual busy=%b done=%b st=%b rd=%0d, required 0/1/0/0",
               busy, done, ap_start, rd_cnt);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    logic v, ov, va;
    logic [DW-1:0] d, od, e;
    int seen0;
    h_start = 1'b1;
    step();
    h_start = 1'b0;
    ap_ready = 1'b1;
    step();
    ap_ready = 1'b0;
    k_ce0 = 1'b1; k_we0 = 1'b0; k_address0 = 10'd7;
    step();
    k_ce0 = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || rd_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL pre_reset_run: actual busy=%b rd=%0d, required 1/1", busy, rd_cnt);
    end
    seen0 = done_seen;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (ap_start !== 1'b0 || busy !== 1'b0 || rd_cnt !== 32'd0 || wr_cnt !== 32'd0 || o_oor_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: actual st=%b busy=%b rd=%0d wr=%0d oor=%b, required all 0",
               ap_start, busy, rd_cnt, wr_cnt, o_oor_err);
    end
    step(); step();
    @(negedge clk);
    rst = 1'b1;
    step();
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || done_seen != seen0) begin
      n_fail++;
      $display("FAIL post_reset_idle_run: actual busy=%b dones=%0d, required 0/0", busy, done_seen - seen0);
    end
    exp_q.push_back(32'hA5A5_0001);
    exp_q.push_back(32'h0000_1234);
    host_read(10'd5, v, d, ov, od, va);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL mem_kept_5: actual %h, required %h", d, e);
    end
    host_read(10'd7, v, d, ov, od, va);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL mem_kept_7: actual %h, required %h", d, e);
    end
  endtask

  initial begin
    test_reset();
    test_out_of_range();
    test_host_preload();
    test_kernel_read();
    test_arbitration();
    test_ap_ctrl_run();
    test_ready_done_same_cycle();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
